// File: rtl/pc_seq_pkg.sv
// ============================================================================
// Module      : pc_seq_pkg
// Description : Shared types and next-PC source encoding for pc_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pc_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } run_state_t;

    // Next-PC source selected by the run-control priority chain
    localparam logic [2:0] SRC_HOLD   = 3'd0;
    localparam logic [2:0] SRC_START  = 3'd1;
    localparam logic [2:0] SRC_TARGET = 3'd2;
    localparam logic [2:0] SRC_INC    = 3'd3;
    localparam logic [2:0] SRC_BRANCH = 3'd4;
    localparam logic [2:0] SRC_POP    = 3'd5;

endpackage

`default_nettype wire

// File: rtl/ret_stack.sv
// ============================================================================
// Module      : ret_stack
// Description : Parametrised LIFO holding call return addresses.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ret_stack #(
    parameter int PC_W        = 10,
    parameter int STACK_DEPTH = 4
) (
    input  logic            Clk_i,
    input  logic            Reset_i,
    input  logic            clear_i,
    input  logic            push_i,
    input  logic            pop_i,
    input  logic [PC_W-1:0] din_i,
    output logic [PC_W-1:0] dout_o,
    output logic            full_o,
    output logic            empty_o
);

    localparam int IDX_W = $clog2(STACK_DEPTH);
    localparam int PTR_W = IDX_W + 1;

    logic [PC_W-1:0]  mem_q [STACK_DEPTH];
    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] ptr_d;
    logic [PTR_W-1:0] w_ptr_m1;
    logic             w_do_push;

    assign full_o    = (ptr_q == PTR_W'(STACK_DEPTH));
    assign empty_o   = (ptr_q == '0);
    assign w_ptr_m1  = ptr_q - PTR_W'(1);
    assign dout_o    = mem_q[w_ptr_m1[IDX_W-1:0]];
    assign w_do_push = push_i && !full_o && !clear_i;

    always_comb begin
        ptr_d = ptr_q;
        if (clear_i) begin
            ptr_d = '0;
        end else if (push_i && !full_o) begin
            ptr_d = ptr_q + PTR_W'(1);
        end else if (pop_i && !empty_o) begin
            ptr_d = w_ptr_m1;
        end
    end

    always_ff @(posedge Clk_i) begin
        if (Reset_i) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    // Entries need no reset: they are only read after being pushed
    always_ff @(posedge Clk_i) begin
        if (w_do_push) begin
            mem_q[ptr_q[IDX_W-1:0]] <= din_i;
        end
    end

endmodule

`default_nettype wire

// File: rtl/pc_sequencer.sv
// ============================================================================
// Module      : pc_sequencer
// Description : Program-counter sequencer with branch, call/return stack and
//               IDLE/RUN/DONE run control.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int PC_W        = 10,
    parameter int STACK_DEPTH = 4,
    parameter int START_ADDR  = 0,
    parameter int REL_BRANCH  = 1
) (
    input  logic            Clk_i,
    input  logic            Reset_i,
    input  logic            Start_i,
    input  logic            Stall_i,
    input  logic            Halt_i,
    input  logic            Jump_i,
    input  logic            BOE_i,
    input  logic            IsEqual_i,
    input  logic            Call_i,
    input  logic            Ret_i,
    input  logic [PC_W-1:0] Target_i,
    output logic [PC_W-1:0] ProgCtr_o,
    output logic            Running_o,
    output logic            Done_o,
    output logic            StackErr_o
);

    run_state_t      state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic            err_q, err_d;
    logic            running_q, running_d;
    logic            done_q, done_d;

    logic [2:0]      w_src;
    logic            w_push, w_pop, w_clear, w_err_set;
    logic            w_full, w_empty;
    logic [PC_W-1:0] w_top;

    ret_stack #(
        .PC_W        (PC_W),
        .STACK_DEPTH (STACK_DEPTH)
    ) u_ret_stack (
        .Clk_i   (Clk_i),
        .Reset_i (Reset_i),
        .clear_i (w_clear),
        .push_i  (w_push),
        .pop_i   (w_pop),
        .din_i   (pc_q + PC_W'(1)),
        .dout_o  (w_top),
        .full_o  (w_full),
        .empty_o (w_empty)
    );

    always_ff @(posedge Clk_i) begin
        if (Reset_i) begin
            state_q   <= ST_IDLE;
            pc_q      <= '0;
            err_q     <= 1'b0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            err_q     <= err_d;
            running_q <= running_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        w_src     = SRC_HOLD;
        w_push    = 1'b0;
        w_pop     = 1'b0;
        w_clear   = 1'b0;
        w_err_set = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (Start_i) begin
                    state_d = ST_RUN;
                    w_src   = SRC_START;
                    w_clear = 1'b1;
                end
            end
            ST_RUN: begin
                if (Start_i) begin
                    w_src   = SRC_START;
                    w_clear = 1'b1;
                end else if (Halt_i) begin
                    state_d = ST_DONE;
                end else if (Stall_i) begin
                    w_src = SRC_HOLD;
                end else if (Jump_i) begin
                    w_src = SRC_TARGET;
                end else if (Call_i) begin
                    // A call on a full stack still jumps; only the push is lost
                    w_src     = SRC_TARGET;
                    w_push    = !w_full;
                    w_err_set = w_full;
                end else if (Ret_i) begin
                    w_src     = w_empty ? SRC_INC : SRC_POP;
                    w_pop     = !w_empty;
                    w_err_set = w_empty;
                end else if (BOE_i && IsEqual_i) begin
                    w_src = SRC_BRANCH;
                end else begin
                    w_src = SRC_INC;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        pc_d = pc_q;
        case (w_src)
            SRC_START:  pc_d = PC_W'(START_ADDR);
            SRC_TARGET: pc_d = Target_i;
            SRC_INC:    pc_d = pc_q + PC_W'(1);
            SRC_BRANCH: pc_d = (REL_BRANCH != 0) ? (pc_q + Target_i) : Target_i;
            SRC_POP:    pc_d = w_top;
            default:    pc_d = pc_q;
        endcase
        err_d     = err_q | w_err_set;
        running_d = (state_d == ST_RUN);
        done_d    = (state_d == ST_DONE);
    end

    assign ProgCtr_o  = pc_q;
    assign Running_o  = running_q;
    assign Done_o     = done_q;
    assign StackErr_o = err_q;

endmodule

`default_nettype wire

// File: tb/tb_pc_sequencer.sv
// ============================================================================
// Module      : tb_pc_sequencer
// Description : Self-checking bench for pc_sequencer with a queue-based model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pc_sequencer;

    localparam int PC_W   = 10;
    localparam int DEPTH  = 4;
    localparam int START  = 0;
    localparam int MASK   = (1 << PC_W) - 1;
    localparam int S_IDLE = 0;
    localparam int S_RUN  = 1;
    localparam int S_DONE = 2;

    logic            clk = 1'b0;
    logic            reset, start, stall, halt, jump, boe, iseq, call, ret;
    logic [PC_W-1:0] target;
    logic [PC_W-1:0] pc;
    logic            running, done, serr;

    int total = 0;
    int bad   = 0;

    int m_pc;
    int m_state;
    bit m_err;
    int m_stk[$];

    pc_sequencer #(
        .PC_W        (PC_W),
        .STACK_DEPTH (DEPTH),
        .START_ADDR  (START),
        .REL_BRANCH  (1)
    ) dut (
        .Clk_i      (clk),
        .Reset_i    (reset),
        .Start_i    (start),
        .Stall_i    (stall),
        .Halt_i     (halt),
        .Jump_i     (jump),
        .BOE_i      (boe),
        .IsEqual_i  (iseq),
        .Call_i     (call),
        .Ret_i      (ret),
        .Target_i   (target),
        .ProgCtr_o  (pc),
        .Running_o  (running),
        .Done_o     (done),
        .StackErr_o (serr)
    );

    always #5 clk = ~clk;

    task automatic idle_inputs();
        reset = 0; start = 0; stall = 0; halt = 0; jump = 0;
        boe = 0; iseq = 0; call = 0; ret = 0; target = '0;
    endtask

    task automatic model_update();
        if (reset) begin
            m_pc = 0; m_state = S_IDLE; m_err = 0; m_stk.delete();
        end else if (m_state != S_RUN) begin
            if (start) begin
                m_state = S_RUN; m_pc = START; m_stk.delete();
            end
        end else if (start) begin
            m_pc = START; m_stk.delete();
        end else if (halt) begin
            m_state = S_DONE;
        end else if (stall) begin
            m_pc = m_pc;
        end else if (jump) begin
            m_pc = int'(target);
        end else if (call) begin
            if (m_stk.size() == DEPTH) m_err = 1;
            else m_stk.push_back((m_pc + 1) & MASK);
            m_pc = int'(target);
        end else if (ret) begin
            if (m_stk.size() == 0) begin
                m_err = 1; m_pc = (m_pc + 1) & MASK;
            end else begin
                m_pc = m_stk.pop_back();
            end
        end else if (boe && iseq) begin
            m_pc = (m_pc + int'(target)) & MASK;
        end else begin
            m_pc = (m_pc + 1) & MASK;
        end
    endtask

    task automatic tick();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1;
        tick();
        total++;
        if ({pc, running, done, serr} !== {10'h000, 3'b000}) begin
            bad++;
            $display("FAIL reset pc=%h run=%b done=%b err=%b want 000/0/0/0", pc, running, done, serr);
        end
        reset = 0;
        jump = 1; target = 10'h155;
        tick();
        total++;
        if ({pc, running} !== {10'h000, 1'b0}) begin
            bad++;
            $display("FAIL idle_ignore pc=%h run=%b want 000/0", pc, running);
        end
        idle_inputs();
    endtask

    task automatic test_sequential();
        start = 1;
        tick();
        start = 0;
        total++;
        if ({pc, running, done} !== {10'h000, 2'b10}) begin
            bad++;
            $display("FAIL start pc=%h run=%b done=%b want 000/1/0", pc, running, done);
        end
        for (int i = 1; i <= 5; i++) begin
            tick();
            total++;
            if (pc !== PC_W'(i)) begin
                bad++;
                $display("FAIL incr pc=%h want %h", pc, PC_W'(i));
            end
        end
    endtask

    task automatic test_branch();
        tick(); tick();
        jump = 1; target = 10'h200;
        tick();
        total++;
        if (pc !== 10'h200) begin bad++; $display("FAIL jump pc=%h want 200", pc); end
        target = 10'h010;
        tick();
        jump = 0; boe = 1; iseq = 1; target = 10'h3FE;
        tick();
        total++;
        if (pc !== 10'h00E) begin bad++; $display("FAIL boe_taken pc=%h want 00e", pc); end
        boe = 0; iseq = 0; jump = 1; target = 10'h010;
        tick();
        jump = 0; boe = 1; iseq = 0; target = 10'h3FE;
        tick();
        total++;
        if (pc !== 10'h011) begin bad++; $display("FAIL boe_not_taken pc=%h want 011", pc); end
        idle_inputs();
    endtask

    task automatic test_call_ret();
        logic [PC_W-1:0] ra [4];
        logic [PC_W-1:0] prev;
        jump = 1; target = 10'h020;
        tick();
        jump = 0; call = 1; target = 10'h100;
        tick();
        total++;
        if (pc !== 10'h100) begin bad++; $display("FAIL call pc=%h want 100", pc); end
        call = 0; ret = 1;
        tick();
        total++;
        if (pc !== 10'h021) begin bad++; $display("FAIL ret pc=%h want 021", pc); end
        ret = 0;
        prev = 10'h021;
        for (int i = 0; i < 4; i++) begin
            ra[i] = prev + 10'd1;
            prev = PC_W'((i + 1) * 'h40);
            call = 1; target = prev;
            tick();
        end
        call = 0;
        for (int i = 3; i >= 0; i--) begin
            ret = 1;
            tick();
            total++;
            if (pc !== ra[i]) begin bad++; $display("FAIL nested_ret%0d pc=%h want %h", i, pc, ra[i]); end
        end
        idle_inputs();
    endtask

    task automatic test_stack_err();
        for (int i = 0; i < 4; i++) begin
            call = 1; target = PC_W'((i + 1) * 'h40);
            tick();
        end
        total++;
        if (serr !== 1'b0) begin bad++; $display("FAIL fill_no_err err=%b want 0", serr); end
        target = 10'h123;
        tick();
        total++;
        if ({pc, serr} !== {10'h123, 1'b1}) begin
            bad++;
            $display("FAIL overflow pc=%h err=%b want 123/1", pc, serr);
        end
        call = 0; start = 1;
        tick();
        start = 0; jump = 1; target = 10'h050;
        tick();
        jump = 0; ret = 1;
        tick();
        total++;
        if ({pc, serr} !== {10'h051, 1'b1}) begin
            bad++;
            $display("FAIL underflow pc=%h err=%b want 051/1", pc, serr);
        end
        idle_inputs();
    endtask

    task automatic test_stall_halt();
        call = 1; target = 10'h060;
        tick();
        call = 0; stall = 1; jump = 1; target = 10'h300;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (pc !== 10'h060) begin bad++; $display("FAIL stall%0d pc=%h want 060", i, pc); end
        end
        stall = 0; jump = 0; halt = 1;
        tick();
        halt = 0;
        total++;
        if ({pc, running, done} !== {10'h060, 2'b01}) begin
            bad++;
            $display("FAIL halt pc=%h run=%b done=%b want 060/0/1", pc, running, done);
        end
        jump = 1; call = 1; target = 10'h2AA;
        tick(); tick();
        total++;
        if ({pc, done} !== {10'h060, 1'b1}) begin
            bad++;
            $display("FAIL done_hold pc=%h done=%b want 060/1", pc, done);
        end
        idle_inputs();
        start = 1;
        tick();
        start = 0;
        total++;
        if ({pc, running, done} !== {PC_W'(START), 2'b10}) begin
            bad++;
            $display("FAIL restart pc=%h run=%b done=%b want %h/1/0", pc, running, done, PC_W'(START));
        end
        ret = 1;
        tick();
        total++;
        if (pc !== PC_W'(START + 1)) begin
            bad++;
            $display("FAIL restart_stack_empty pc=%h want %h", pc, PC_W'(START + 1));
        end
        idle_inputs();
    endtask

    task automatic test_reset_midrun();
        call = 1; target = 10'h0AB; reset = 1;
        tick();
        idle_inputs();
        total++;
        if ({pc, running, done, serr} !== {10'h000, 3'b000}) begin
            bad++;
            $display("FAIL reset_midrun pc=%h run=%b done=%b err=%b want 000/0/0/0", pc, running, done, serr);
        end
        start = 1;
        tick();
        start = 0; jump = 1; target = 10'h3FF;
        tick();
        jump = 0;
        tick();
        total++;
        if (pc !== 10'h000) begin bad++; $display("FAIL wrap pc=%h want 000", pc); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            reset  = ($urandom_range(99) < 2);
            start  = ($urandom_range(99) < 5);
            halt   = ($urandom_range(99) < 4);
            stall  = ($urandom_range(99) < 12);
            jump   = ($urandom_range(99) < 12);
            call   = ($urandom_range(99) < 25);
            ret    = ($urandom_range(99) < 25);
            boe    = ($urandom_range(99) < 40);
            iseq   = ($urandom_range(99) < 50);
            target = PC_W'($urandom);
            if (m_state != S_RUN && $urandom_range(99) < 40) start = 1;
            tick();
            total++;
            if ({pc, running, done, serr} !==
                {PC_W'(m_pc), m_state == S_RUN, m_state == S_DONE, m_err}) begin
                bad++;
                $display("FAIL random%0d pc=%h run=%b done=%b err=%b want %h/%b/%b/%b", n,
                         pc, running, done, serr, PC_W'(m_pc),
                         m_state == S_RUN, m_state == S_DONE, m_err);
            end
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        reset = 1;
        test_reset();
        test_sequential();
        test_branch();
        test_call_ret();
        test_stack_err();
        test_stall_halt();
        test_reset_midrun();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
